mips_boot_loader: RTL and testbench

//  Boot/program-load sequencer for the pipelined MIPS core. Accepts a valid/ready word stream,

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_boot_checksum.sv | 43 ++++
 rtl/mips_boot_loader.sv | 140 ++++++++++++++
 tb/tb_mips_boot_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS boot/program-load sequencer.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        ERROR
    } boot_state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mips_boot_checksum.sv
// Running modulo-2^32 sum of loaded program words, compared against an expected value
// at the end of the flush window. Only instantiated when MIPS_BOOT_CHECKSUM_EN is defined.
module mips_boot_checksum (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        add_en,
    input  logic [31:0] add_data,
    input  logic [31:0] expected_sum,
    input  logic        check_en,
    output logic        sum_match,
    output logic        sum_ok
);

    logic [31:0] sum_q, sum_d;
    logic        sum_ok_q, sum_ok_d;

    assign sum_match = (sum_q == expected_sum);
    assign sum_ok    = sum_ok_q;

    always_comb begin
        sum_d    = sum_q;
        sum_ok_d = sum_ok_q;
        if (clear) begin
            sum_d    = '0;
            sum_ok_d = 1'b0;
        end else begin
            if (add_en)   sum_d    = sum_q + add_data;
            if (check_en) sum_ok_d = sum_match;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q    <= '0;
            sum_ok_q <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            sum_ok_q <= sum_ok_d;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot sequencer: streams program words into instruction memory, holds the pipeline in reset
// through load and flush, then releases it. Define MIPS_BOOT_CHECKSUM_EN to add checksum gating.
module mips_boot_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0,
    parameter int          DEPTH_WORDS  = 256,
    parameter int          FLUSH_CYCLES = 4,
    localparam int         CNT_W        = $clog2(DEPTH_WORDS) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             inst_mem_load_enable,
    output logic [31:0]      inst_mem_write_addr,
    output logic [31:0]      inst_mem_write_data,
    output logic             pc_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
`ifdef MIPS_BOOT_CHECKSUM_EN
    input  logic [31:0]      expected_sum,
    output logic             sum_ok,
`endif
    output logic [CNT_W-1:0] word_count
);

    localparam int FL_W = $clog2(FLUSH_CYCLES) + 1;

    boot_state_t      state_q, state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] wc_q, wc_d;
    logic [FL_W-1:0]  fcnt_q, fcnt_d;

    logic accept, overflow, enter_load, flush_done, chk_pass;

    assign accept     = (state_q == LOAD) && load_valid;
    assign overflow   = (wc_q == CNT_W'(DEPTH_WORDS));
    assign enter_load = start && ((state_q == IDLE) || (state_q == RUN));
    // The first FLUSH cycle carries the final write strobe; counting begins after it.
    assign flush_done = (state_q == FLUSH) && !en_q && (fcnt_q == FL_W'(FLUSH_CYCLES - 1));

`ifdef MIPS_BOOT_CHECKSUM_EN
    mips_boot_checksum u_checksum (
        .clock        (clock),
        .reset        (reset),
        .clear        (enter_load),
        .add_en       (en_d),
        .add_data     (load_data),
        .expected_sum (expected_sum),
        .check_en     (flush_done),
        .sum_match    (chk_pass),
        .sum_ok       (sum_ok)
    );
`else
    assign chk_pass = 1'b1;
`endif

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        en_d    = 1'b0;
        wc_d    = wc_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE, RUN: begin
                if (enter_load) begin
                    state_d = LOAD;
                    ptr_d   = ADDR_BASE;
                    wc_d    = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (overflow) begin
                        state_d = ERROR;
                    end else begin
                        en_d    = 1'b1;
                        waddr_d = ptr_q;
                        wdata_d = load_data;
                        ptr_d   = ptr_q + 32'(WORD_BYTES);
                        wc_d    = wc_q + CNT_W'(1);
                        if (load_last) begin
                            state_d = FLUSH;
                            fcnt_d  = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                if (flush_done)  state_d = chk_pass ? RUN : ERROR;
                else if (!en_q)  fcnt_d  = fcnt_q + FL_W'(1);
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= ADDR_BASE;
            waddr_q <= ADDR_BASE;
            wdata_q <= '0;
            en_q    <= 1'b0;
            wc_q    <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            wc_q    <= wc_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign load_ready           = (state_q == LOAD);
    assign inst_mem_load_enable = en_q;
    assign inst_mem_write_addr  = waddr_q;
    assign inst_mem_write_data  = wdata_q;
    assign pc_reset             = (state_q != RUN);
    assign busy                 = (state_q == LOAD) || (state_q == FLUSH);
    assign done                 = (state_q == RUN);
    assign error                = (state_q == ERROR);
    assign word_count           = wc_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed, table-driven bench for mips_boot_loader (DEPTH_WORDS=4, FLUSH_CYCLES=4, ADDR_BASE=0).
module tb_mips_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        inst_mem_load_enable;
    logic [31:0] inst_mem_write_addr;
    logic [31:0] inst_mem_write_data;
    logic        pc_reset, busy, done, error;
    logic [2:0]  word_count;
`ifdef MIPS_BOOT_CHECKSUM_EN
    logic [31:0] expected_sum = '0;
    logic        sum_ok;
`endif

    mips_boot_loader #(
        .ADDR_BASE    (32'h0),
        .DEPTH_WORDS  (4),
        .FLUSH_CYCLES (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .load_valid           (load_valid),
        .load_ready           (load_ready),
        .load_data            (load_data),
        .load_last            (load_last),
        .inst_mem_load_enable (inst_mem_load_enable),
        .inst_mem_write_addr  (inst_mem_write_addr),
        .inst_mem_write_data  (inst_mem_write_data),
        .pc_reset             (pc_reset),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
`ifdef MIPS_BOOT_CHECKSUM_EN
        .expected_sum         (expected_sum),
        .sum_ok               (sum_ok),
`endif
        .word_count           (word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        start, valid, last;
        logic [31:0] data;
        logic        en;
        logic [31:0] addr, wdata;
        logic        pc, ready, busy, done, err;
        logic [2:0]  wc;
    } vec_t;

    vec_t tbl[17];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] wa[8];
    logic [31:0] wd[8];
    int   nwr;

    function automatic vec_t mk(input logic s, v, l, input logic [31:0] d,
                                input logic en, input logic [31:0] a, w,
                                input logic pc, r, b, dn, e, input logic [2:0] wc);
        vec_t t;
        t.start = s; t.valid = v; t.last = l; t.data = d;
        t.en = en; t.addr = a; t.wdata = w;
        t.pc = pc; t.ready = r; t.busy = b; t.done = dn; t.err = e; t.wc = wc;
        return t;
    endfunction

    function automatic logic [79:0] pack_obs();
        return {7'd0, inst_mem_load_enable, inst_mem_write_addr, inst_mem_write_data,
                pc_reset, load_ready, busy, done, error, word_count};
    endfunction

    function automatic logic [79:0] pack_exp(input vec_t t);
        return {7'd0, t.en, t.addr, t.wdata, t.pc, t.ready, t.busy, t.done, t.err, t.wc};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, v, l, input logic [31:0] d);
        start = s; load_valid = v; load_last = l; load_data = d;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(0, 0, 0, '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic begin_load();
        drive(1, 0, 0, '0);
        @(negedge clock);
        drive(0, 0, 0, '0);
    endtask

    task automatic record_write();
        if (inst_mem_load_enable === 1'b1 && nwr < 8) begin
            wa[nwr] = inst_mem_write_addr;
            wd[nwr] = inst_mem_write_data;
            nwr++;
        end
    endtask

    initial begin
        //          start v l data          en a      wdata         pc r b d e wc
        tbl[0]  = mk(1, 1, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0,        1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 32'h20080005, 0, 32'h0, 32'h0,        1, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 32'h20090007, 1, 32'h0, 32'h20080005, 1, 1, 1, 0, 0, 1);
        tbl[3]  = mk(0, 1, 1, 32'h01095020, 1, 32'h4, 32'h20090007, 1, 1, 1, 0, 0, 2);
        tbl[4]  = mk(0, 0, 0, 32'h0,        1, 32'h8, 32'h01095020, 1, 0, 1, 0, 0, 3);
        tbl[5]  = mk(0, 0, 1, 32'h0,        0, 32'h8, 32'h01095020, 1, 0, 1, 0, 0, 3);
        tbl[6]  = mk(1, 0, 0, 32'h0,        0, 32'h8, 32'h01095020, 1, 0, 1, 0, 0, 3);
        tbl[7]  = mk(0, 0, 0, 32'h0,        0, 32'h8, 32'h01095020, 1, 0, 1, 0, 0, 3);
        tbl[8]  = mk(0, 0, 0, 32'h0,        0, 32'h8, 32'h01095020, 1, 0, 1, 0, 0, 3);
        tbl[9]  = mk(1, 0, 0, 32'h0,        0, 32'h8, 32'h01095020, 0, 0, 0, 1, 0, 3);
        tbl[10] = mk(0, 1, 1, 32'hAC000000, 0, 32'h8, 32'h01095020, 1, 1, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 32'h0,        1, 32'h0, 32'hAC000000, 1, 0, 1, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'hAC000000, 1, 0, 1, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'hAC000000, 1, 0, 1, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'hAC000000, 1, 0, 1, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'hAC000000, 1, 0, 1, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'hAC000000, 0, 0, 0, 1, 0, 1);

`ifdef MIPS_BOOT_CHECKSUM_EN
        expected_sum = 32'h411A502C;
`endif
        do_reset();

        // Main load, flush timing, then a reload from RUN.
        for (int i = 0; i < 17; i++) begin
            check($sformatf("vec%0d", i), pack_obs(), pack_exp(tbl[i]));
`ifdef MIPS_BOOT_CHECKSUM_EN
            if (i == 10) expected_sum = 32'hAC000000;
`endif
            drive(tbl[i].start, tbl[i].valid, tbl[i].last, tbl[i].data);
            @(negedge clock);
        end

        // Gapped stream: valid every other cycle, load_last asserted on idle cycles too.
        do_reset();
        begin_load();
        nwr = 0;
        for (int i = 0; i < 8; i++) begin
            record_write();
            if (i < 5) drive(0, (i % 2) == 0, (i == 4) || (i % 2) == 1, 32'd100 + 32'(i));
            else       drive(0, 0, 0, '0);
            @(negedge clock);
        end
        check("gap_nwr",   80'(nwr), 80'd3);
        check("gap_addr1", 80'(wa[1]), 80'h4);
        check("gap_addr2", 80'(wa[2]), 80'h8);
        check("gap_data0", 80'(wd[0]), 80'd100);
        check("gap_data2", 80'(wd[2]), 80'd104);
        check("gap_wc",    80'(word_count), 80'd3);
        check("gap_busy",  80'({busy, done, load_ready}), 80'b100);

        // Overflow: five beats into a four-word memory, no load_last.
        do_reset();
        begin_load();
        nwr = 0;
        for (int i = 0; i < 8; i++) begin
            record_write();
            if (i < 5) drive(0, 1, 0, 32'h1000 + 32'(i));
            else       drive(0, 0, 0, '0);
            @(negedge clock);
        end
        check("ovf_nwr",   80'(nwr), 80'd4);
        check("ovf_addr3", 80'(wa[3]), 80'hC);
        check("ovf_data3", 80'(wd[3]), 80'h1003);
        check("ovf_flags", 80'({error, pc_reset, load_ready, busy, done}), 80'b11000);
        check("ovf_wc",    80'(word_count), 80'd4);
        drive(1, 0, 0, '0);
        @(negedge clock);
        drive(0, 0, 0, '0);
        @(negedge clock);
        check("ovf_sticky", 80'({error, pc_reset, busy}), 80'b110);

        // Reset asserted while the second beat is offered.
        do_reset();
        begin_load();
        drive(0, 1, 0, 32'h55);
        @(negedge clock);
        check("rst_first_write", 80'({inst_mem_load_enable, inst_mem_write_data}), {47'd0, 1'b1, 32'h55});
        drive(0, 1, 0, 32'h66);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_load", pack_obs(), pack_exp(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0)));
        reset = 1'b0;
        drive(0, 0, 0, '0);
        @(negedge clock);
        check("rst_idle", pack_obs(), pack_exp(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0)));

`ifdef MIPS_BOOT_CHECKSUM_EN
        for (int pass = 0; pass < 2; pass++) begin
            int waited;
            do_reset();
            expected_sum = (pass == 0) ? 32'd6 : 32'd7;
            begin_load();
            for (int i = 1; i <= 3; i++) begin
                drive(0, 1, i == 3, 32'(i));
                @(negedge clock);
            end
            drive(0, 0, 0, '0);
            waited = 0;
            while (!(done || error) && waited < 20) begin
                @(negedge clock);
                waited++;
            end
            check($sformatf("sum_timeout%0d", pass), 80'(waited < 20), 80'd1);
            if (pass == 0) check("sum_pass", 80'({done, error, sum_ok}), 80'b101);
            else           check("sum_fail", 80'({done, error, sum_ok}), 80'b010);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
